inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 cpu_clk  input  1  single clock; all state updates on rising edge.
REQ-002 cpu_rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  begin a session: load address counter from base_addr and clear count.
REQ-004 base_addr  input  14  word address of the first instruction to write.
REQ-005 in_valid / in_ready  input / output  1 / 1  descriptor handshake; transfer when both are high.
REQ-006 in_cls  input  3  class: 0=R(0110011), 1=I(0010011), 2=LW(0000011), 3=JALR(1100111), 4=SW(0100011), 5=B(1100011), 6=U/LUI(0110111), 7=J/JAL(1101111).
REQ-007 in_func3 / in_alt  input  3 / 1  func3, plus alt=1 selects func7=0100000 (SUB, SRA/SRAI).
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-009 in_imm  input  32  unscrambled immediate value (byte offset for B and J).
REQ-010 wr_en / wr_ready  output / input  1 / 1  instruction-RAM write handshake; the write completes when both are high.
REQ-011 wr_addr / wr_data  output  14 / 32  write word address and encoded instruction.
REQ-012 count  output  16  words written this session, saturating at 0xFFFF.
REQ-013 busy  output  1  equals wr_en.
REQ-014 err  output  1  sticky illegal-descriptor flag (see REQ-026).

Function
REQ-015 Encoding:
- R: {alt?0100000:0000000, rs2, rs1, f3, rd, op}.
- I with f3=001/101: {0, alt, 00000, imm[4:0], rs1, f3, rd, op}.
- Other I: {imm[11:0], rs1, f3, rd, op}.
REQ-016 Forced func3:
- LW: {imm[11:0], rs1, 010, rd, op}.
- JALR: {imm[11:0], rs1, 000, rd, op}.
- SW: {imm[11:5], rs2, rs1, 010, imm[4:0], op}.
REQ-017 Remaining classes:
- B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
- U: {imm[31:12], rd, op}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-018 Single output register stage: an accepted descriptor appears on wr_data/wr_en on the next cycle (latency 1).
REQ-019 in_ready = !wr_en || wr_ready. No combinational path from in_valid to in_ready.
REQ-020 While wr_en=1 and wr_ready=0, wr_en, wr_addr and wr_data hold stable.
REQ-021 On each completed write: wr_addr increments by 1, wrapping 0x3FFF to 0x0000; count increments, saturating.
REQ-022 Completion and acceptance in the same cycle: the new word loads at wr_addr+1 with no bubble (one write per cycle sustained).
REQ-023 start has priority over everything:
- discards any pending output word (wr_en=0 next cycle);
- loads wr_addr=base_addr and count=0;
- forces in_ready=0 that cycle;
- clears err.
REQ-024 Descriptors are accepted only after the first start following reset; before that, in_ready=0.

Reset
REQ-025 When cpu_rst=1 at a clock edge: wr_en=0, wr_addr=0, wr_data=0, count=0, err=0, in_ready=0, session inactive. cpu_rst overrides start. Any in-flight word is lost.

Configuration
REQ-026 Macro ENC_CHECK_EN defined, illegal descriptors are consumed (in_ready handshake completes), no write is issued, and err is set. Illegal means any of:
- R with f3 in {010, 011};
- alt=1 with f3 not in {000, 101};
- I with f3=011;
- B with f3 not in {000, 001, 100, 101};
- B or J with imm[0]=1;
- I/LW/JALR/SW imm outside [-2048, 2047];
- B imm outside [-4096, 4094].
REQ-027 Macro ENC_CHECK_EN undefined: every descriptor is encoded per REQ-015..017 with no checking; err is tied to 0.

Verification
REQ-028 Basic encodings, after start with base_addr=0x0010:
- R add x3,x1,x2 -> wr_data=0x002081B3 at wr_addr=0x0010;
- alt=1 (sub) -> 0x402081B3 at 0x0011;
- count=2.
REQ-029 LW x5,8(x2) -> 0x00812283; SW x5,12(x2) -> 0x00512623; LUI x1,0x12345 (imm=0x12345000) -> 0x123450B7.
REQ-030 BEQ x1,x2,imm=-4 -> 0xFE208EE3. Back-to-back descriptors with wr_ready=1 -> one write per cycle, no gaps.
REQ-031 Backpressure: hold wr_ready=0 for 3 cycles with a word pending -> wr_data/wr_addr stable, in_ready=0, count unchanged. Releasing wr_ready -> write completes and the next descriptor is accepted in that cycle.
REQ-032 Wrap, start and reset:
- base_addr=0x3FFF with two writes -> wr_addr 0x3FFF then 0x0000;
- start asserted with a stalled word pending -> word dropped, wr_en=0, wr_addr=base_addr;
- cpu_rst mid-stream -> all outputs zero next cycle.
REQ-033 With ENC_CHECK_EN defined: B descriptor with imm=3 -> no write, err=1 and held until start. Without ENC_CHECK_EN: the same descriptor is written and err=0.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs descriptors into words and streams them to instruction RAM.
// Optional descriptor legality checking is enabled by defining ENC_CHECK_EN.
module inst_encoder (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        start,
    input  logic [13:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_cls,
    input  logic [2:0]  in_func3,
    input  logic        in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        wr_en,
    input  logic        wr_ready,
    output logic [13:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [15:0] count,
    output logic        busy,
    output logic        err
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_U    = 7'b0110111;
    localparam logic [6:0] OP_J    = 7'b1101111;

    logic        session;
    logic        accept;
    logic        complete;
    logic        illegal;
    logic [31:0] enc;

    logic c_r, c_i, c_lw, c_jalr, c_sw, c_b, c_u, c_j;

    assign c_r    = (in_cls == 3'd0);
    assign c_i    = (in_cls == 3'd1);
    assign c_lw   = (in_cls == 3'd2);
    assign c_jalr = (in_cls == 3'd3);
    assign c_sw   = (in_cls == 3'd4);
    assign c_b    = (in_cls == 3'd5);
    assign c_u    = (in_cls == 3'd6);
    assign c_j    = (in_cls == 3'd7);

    // Readiness depends only on registered state and the control inputs.
    assign in_ready = session && !start && !cpu_rst && (!wr_en || wr_ready);
    assign accept   = in_valid && in_ready;
    assign complete = wr_en && wr_ready;
    assign busy     = wr_en;

    always_comb begin
        enc = '0;
        unique case (1'b1)
            c_r: begin
                enc = {(in_alt ? 7'b0100000 : 7'b0000000), in_rs2, in_rs1,
                       in_func3, in_rd, OP_R};
            end
            c_i: begin
                if (in_func3 == 3'b001 || in_func3 == 3'b101) begin
                    enc = {1'b0, in_alt, 5'b00000, in_imm[4:0], in_rs1,
                           in_func3, in_rd, OP_I};
                end else begin
                    enc = {in_imm[11:0], in_rs1, in_func3, in_rd, OP_I};
                end
            end
            c_lw: begin
                enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LW};
            end
            c_jalr: begin
                enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
            end
            c_sw: begin
                enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                       in_imm[4:0], OP_SW};
            end
            c_b: begin
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                       in_imm[4:1], in_imm[11], OP_B};
            end
            c_u: begin
                enc = {in_imm[31:12], in_rd, OP_U};
            end
            c_j: begin
                enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                       in_rd, OP_J};
            end
            default: enc = '0;
        endcase
    end

`ifdef ENC_CHECK_EN
    logic imm12_ok;
    logic imm13_ok;
    logic err_q;

    // Sign-extension checks: all bits above the field must match its sign.
    assign imm12_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign imm13_ok = (&in_imm[31:12]) || !(|in_imm[31:12]);

    always_comb begin
        illegal = 1'b0;
        if (c_r && (in_func3 == 3'b010 || in_func3 == 3'b011)) begin
            illegal = 1'b1;
        end
        if (in_alt && !(in_func3 == 3'b000 || in_func3 == 3'b101)) begin
            illegal = 1'b1;
        end
        if (c_i && in_func3 == 3'b011) begin
            illegal = 1'b1;
        end
        if (c_b && !(in_func3 == 3'b000 || in_func3 == 3'b001 ||
                     in_func3 == 3'b100 || in_func3 == 3'b101)) begin
            illegal = 1'b1;
        end
        if ((c_b || c_j) && in_imm[0]) begin
            illegal = 1'b1;
        end
        if ((c_i || c_lw || c_jalr || c_sw) && !imm12_ok) begin
            illegal = 1'b1;
        end
        if (c_b && !imm13_ok) begin
            illegal = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            err_q <= 1'b0;
        end else if (start) begin
            err_q <= 1'b0;
        end else if (accept && illegal) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_imm;

    assign unused_imm = in_imm[0];
    assign illegal    = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            session <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            count   <= '0;
        end else if (start) begin
            session <= 1'b1;
            wr_en   <= 1'b0;
            wr_addr <= base_addr;
            count   <= '0;
        end else begin
            if (complete) begin
                wr_addr <= wr_addr + 14'd1;
                if (count != 16'hFFFF) begin
                    count <= count + 16'd1;
                end
            end
            // Acceptance implies the output slot is empty or draining now.
            if (accept) begin
                wr_en <= !illegal;
                if (!illegal) begin
                    wr_data <= enc;
                end
            end else if (complete) begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table, scoreboard queue and
// hand-written sequences for stall, wrap, start, reset and illegal descriptors.
module tb_inst_encoder;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        start;
    logic [13:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_cls;
    logic [2:0]  in_func3;
    logic        in_alt;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        wr_en;
    logic        wr_ready;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] count;
    logic        busy;
    logic        err;

    inst_encoder dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .start    (start),
        .base_addr(base_addr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_cls   (in_cls),
        .in_func3 (in_func3),
        .in_alt   (in_alt),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_imm   (in_imm),
        .wr_en    (wr_en),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .count    (count),
        .busy     (busy),
        .err      (err)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[12];
    logic [31:0] sb_q[$];
    logic [13:0] m_addr = '0;
    logic [15:0] m_cnt = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Completion monitor: mid-cycle sample of the handshake that fires next edge.
    always @(negedge cpu_clk) begin
        if (cpu_rst) begin
            sb_q.delete();
            m_addr = '0;
            m_cnt  = '0;
        end else if (start) begin
            sb_q.delete();
            m_addr = base_addr;
            m_cnt  = '0;
        end else if (wr_en && wr_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", wr_data, 32'hDEADBEEF);
            end else begin
                chk("wr_data", wr_data, sb_q.pop_front());
                chk("wr_addr", {18'd0, wr_addr}, {18'd0, m_addr});
            end
            m_addr = m_addr + 14'd1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_desc(input int i);
        in_cls   = tbl[i].cls;
        in_func3 = tbl[i].f3;
        in_alt   = tbl[i].alt;
        in_rd    = tbl[i].rd;
        in_rs1   = tbl[i].rs1;
        in_rs2   = tbl[i].rs2;
        in_imm   = tbl[i].imm;
        in_valid = 1'b1;
    endtask

    task automatic send(input int i, output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        set_desc(i);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge cpu_clk);
            if (in_ready) begin
                got = 1'b1;
            end else begin
                waits++;
                @(posedge cpu_clk);
                #1;
            end
        end
        if (got) begin
            sb_q.push_back(tbl[i].exp);
            @(posedge cpu_clk);
            #1;
        end else begin
            chk("send_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [13:0] b);
        start     = 1'b1;
        base_addr = b;
        @(negedge cpu_clk);
        chk("start_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge cpu_clk);
        #1;
        start = 1'b0;
        chk("start_wr_en", {31'd0, wr_en}, 32'd0);
        chk("start_addr", {18'd0, wr_addr}, {18'd0, b});
        chk("start_count", {16'd0, count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        tbl[0]  = '{3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0,         32'h002081B3};
        tbl[1]  = '{3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,         32'h402081B3};
        tbl[2]  = '{3'd2, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8,         32'h00812283};
        tbl[3]  = '{3'd4, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 32'd12,        32'h00512623};
        tbl[4]  = '{3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h12345000,  32'h123450B7};
        tbl[5]  = '{3'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,  32'hFE208EE3};
        tbl[6]  = '{3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF,  32'hFFF00093};
        tbl[7]  = '{3'd1, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3,         32'h40335293};
        tbl[8]  = '{3'd1, 3'd1, 1'b0, 5'd2, 5'd2, 5'd0, 32'd31,        32'h01F11113};
        tbl[9]  = '{3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         32'h008000EF};
        tbl[10] = '{3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0,         32'h00008067};
        tbl[11] = '{3'd5, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,         32'h00209463};

        cpu_rst   = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b1;
        in_cls    = '0;
        in_func3  = '0;
        in_alt    = 1'b0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        wr_ready  = 1'b1;

        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_addr", {18'd0, wr_addr}, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_count", {16'd0, count}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        chk("pre_start_ready", {31'd0, in_ready}, 32'd0);
        @(posedge cpu_clk);
        #1;
        in_valid = 1'b0;

        // Basic encodings and address/count progression
        do_start(14'h0010);
        send(0, w);
        send(1, w);
        idle(3);
        chk("count_two", {16'd0, count}, 32'd2);
        chk("addr_after_two", {18'd0, wr_addr}, 32'h12);

        // Back-to-back stream: every descriptor must be taken first try
        for (int i = 2; i < 12; i++) begin
            send(i, w);
            chk($sformatf("b2b_wait_%0d", i), w, 32'd0);
        end
        idle(3);
        chk("count_stream", {16'd0, count}, 32'd12);
        chk("addr_stream", {18'd0, wr_addr}, 32'h1C);
        chk("busy_idle", {31'd0, busy}, 32'd0);

        // Backpressure: pending word holds, then drains while the next is taken
        wr_ready = 1'b0;
        send(0, w);
        set_desc(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge cpu_clk);
            chk("stall_wr_en", {31'd0, wr_en}, 32'd1);
            chk("stall_data", wr_data, 32'h002081B3);
            chk("stall_addr", {18'd0, wr_addr}, 32'h1C);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_count", {16'd0, count}, 32'd12);
            @(posedge cpu_clk);
            #1;
        end
        wr_ready = 1'b1;
        send(1, w);
        chk("release_accept_wait", w, 32'd0);
        idle(3);
        chk("count_release", {16'd0, count}, 32'd14);
        chk("addr_release", {18'd0, wr_addr}, 32'h1E);

        // Address wrap at the top of the RAM
        do_start(14'h3FFF);
        send(4, w);
        send(5, w);
        idle(3);
        chk("wrap_addr", {18'd0, wr_addr}, 32'h1);
        chk("wrap_count", {16'd0, count}, 32'd2);

        // start drops a stalled word
        wr_ready = 1'b0;
        send(6, w);
        chk("stalled_wr_en", {31'd0, wr_en}, 32'd1);
        do_start(14'h0100);
        wr_ready = 1'b1;
        idle(2);
        chk("start_drop_wr_en", {31'd0, wr_en}, 32'd0);
        chk("start_drop_count", {16'd0, count}, 32'd0);

        // Reset mid-stream
        wr_ready = 1'b0;
        send(7, w);
        cpu_rst = 1'b1;
        @(posedge cpu_clk);
        #1;
        chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst_addr", {18'd0, wr_addr}, 32'd0);
        chk("midrst_data", wr_data, 32'd0);
        chk("midrst_count", {16'd0, count}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        cpu_rst  = 1'b0;
        wr_ready = 1'b1;
        idle(1);
        chk("midrst_no_session", {31'd0, in_ready}, 32'd0);

        // Misaligned branch offset
        do_start(14'h0020);
        in_cls   = 3'd5;
        in_func3 = 3'd0;
        in_alt   = 1'b0;
        in_rd    = 5'd0;
        in_rs1   = 5'd1;
        in_rs2   = 5'd2;
        in_imm   = 32'd3;
        in_valid = 1'b1;
        @(negedge cpu_clk);
        chk("bad_b_ready", {31'd0, in_ready}, 32'd1);
`ifndef ENC_CHECK_EN
        sb_q.push_back(32'h00208163);
`endif
        @(posedge cpu_clk);
        #1;
        in_valid = 1'b0;
        idle(3);
`ifdef ENC_CHECK_EN
        chk("bad_b_err", {31'd0, err}, 32'd1);
        chk("bad_b_count", {16'd0, count}, 32'd0);
        idle(3);
        chk("bad_b_err_sticky", {31'd0, err}, 32'd1);
        do_start(14'h0020);
        chk("err_cleared", {31'd0, err}, 32'd0);
`else
        chk("bad_b_err", {31'd0, err}, 32'd0);
        chk("bad_b_count", {16'd0, count}, 32'd1);
`endif

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
